signed_bcd_display_unit: RTL and testbench

- Sequential display stage that sits directly downstream of the 2:1 input/result multiplexer in the calculator.
- Takes an 8-bit value (keypad entry or AU result) on a Start strobe and converts it to sign-magnitude BCD using an iterative shift-add-3 (double-dabble) engine.
- Drives four active-low seven-segment displays: Hex3 = sign, Hex2..Hex0 = hundreds/tens/ones.
- Results are registered and held, so displays never show intermediate conversion states.

---
 rtl/signed_bcd_display_unit_pkg.sv | 30 +++
 rtl/signed_bcd_display_unit_seg7.sv | 39 +++
 rtl/signed_bcd_display_unit.sv | 201 ++++++++++++++++++++
 tb/tb_signed_bcd_display_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_bcd_display_unit_pkg.sv
// -----------------------------------------------------------------------------
// signed_bcd_display_unit_pkg
// Shared definitions for the signed BCD display stage:
//   - state_t      : conversion FSM states (IDLE, CONVERT, LOAD, DONE)
//   - SEG_*        : active-low seven-segment patterns {g,f,e,d,c,b,a}
//   - ITERATIONS   : number of shift-add-3 steps for an 8-bit magnitude
//   - addThree     : the double-dabble nibble correction step
// -----------------------------------------------------------------------------
package signed_bcd_display_unit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LOAD    = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   localparam int unsigned ITERATIONS = 8;

   // A BCD nibble of 5 or more would overflow past 9 after the next doubling,
   // so it is pre-biased by 3 to carry correctly into the next decade.
   function automatic logic [3:0] addThree(input logic [3:0] nibble);
      return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
   endfunction

endpackage

// File: rtl/signed_bcd_display_unit_seg7.sv
// -----------------------------------------------------------------------------
// seg7_digit_decoder
// Combinational BCD-to-seven-segment decoder, active-low outputs.
// Ports:
//   digit_i [3:0] : BCD digit 0..9
//   blank_i       : force the display dark
//   seg_o   [6:0] : segments {g,f,e,d,c,b,a}, 0 = lit
// Codes 10..15 cannot come from a correct conversion; they show dark so a
// fault is visible as a missing digit rather than a misleading one.
// -----------------------------------------------------------------------------
module seg7_digit_decoder
   import signed_bcd_display_unit_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   // Digit lookup; blanking overrides the digit entirely.
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = SEG_ZERO;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/signed_bcd_display_unit.sv
// -----------------------------------------------------------------------------
// signed_bcd_display_unit
// Converts an 8-bit value to sign-magnitude BCD with an iterative
// double-dabble engine and drives four active-low seven-segment displays.
// All visible outputs are registered and only change in the LOAD state, so the
// displays never show partial conversion results.
// Ports:
//   clock_i, reset_i (async, active-high)
//   start_i         : convert request, honoured only in IDLE
//   value_i  [7:0]  : number to convert, sampled on the accepting edge
//   busy_o          : conversion in progress (CONVERT/LOAD)
//   done_o          : one-cycle pulse, new result visible
//   negative_o      : sign of last result
//   ones_o, tens_o, hundreds_o [3:0] : BCD digits of last result
//   hex0_o..hex2_o [6:0] : ones/tens/hundreds segments
//   hex3_o [6:0]    : minus sign or blank
// -----------------------------------------------------------------------------
module signed_bcd_display_unit
   import signed_bcd_display_unit_pkg::*;
#(
   parameter bit SIGNED_MODE   = 1'b1,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [7:0] value_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       negative_o,
   output logic [3:0] ones_o,
   output logic [3:0] tens_o,
   output logic [3:0] hundreds_o,
   output logic [6:0] hex0_o,
   output logic [6:0] hex1_o,
   output logic [6:0] hex2_o,
   output logic [6:0] hex3_o
);

   localparam logic [3:0] LAST_ITER    = 4'(ITERATIONS - 1);
   localparam logic [6:0] LEAD_RESET   = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  mag_q, mag_d;
   logic [11:0] scratch_q, scratch_d;
   logic        sign_q, sign_d;
   logic        neg_q, neg_d;
   logic [3:0]  ones_q, ones_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  hundreds_q, hundreds_d;
   logic [6:0]  hex0_q, hex0_d;
   logic [6:0]  hex1_q, hex1_d;
   logic [6:0]  hex2_q, hex2_d;
   logic [6:0]  hex3_q, hex3_d;

   logic        signIn;
   logic [7:0]  magIn;
   logic [11:0] adjustedBcd;
   logic [19:0] shiftedWord;
   logic        blankHundreds;
   logic        blankTens;
   logic [6:0]  segOnes;
   logic [6:0]  segTens;
   logic [6:0]  segHundreds;

   // In unsigned mode bit 7 is plain magnitude, so the sign is forced low.
   // Negating 0x80 wraps to 0x80, which reads correctly as 128 unsigned.
   assign signIn = SIGNED_MODE & value_i[7];
   assign magIn  = signIn ? 8'(~value_i + 8'd1) : value_i;

   // One double-dabble step: correct every decade, then shift the magnitude's
   // MSB into the BCD scratch register.
   assign adjustedBcd = {addThree(scratch_q[11:8]), addThree(scratch_q[7:4]),
                         addThree(scratch_q[3:0])};
   assign shiftedWord = {adjustedBcd, mag_q} << 1;

   // Leading-zero suppression on the freshly converted digits; the tens digit
   // stays lit whenever a nonzero hundreds digit precedes it.
   assign blankHundreds = BLANK_LEADING && (scratch_q[11:8] == 4'd0);
   assign blankTens     = blankHundreds && (scratch_q[7:4] == 4'd0);

   seg7_digit_decoder uOnesDecoder (
      .digit_i (scratch_q[3:0]),
      .blank_i (1'b0),
      .seg_o   (segOnes)
   );

   seg7_digit_decoder uTensDecoder (
      .digit_i (scratch_q[7:4]),
      .blank_i (blankTens),
      .seg_o   (segTens)
   );

   seg7_digit_decoder uHundredsDecoder (
      .digit_i (scratch_q[11:8]),
      .blank_i (blankHundreds),
      .seg_o   (segHundreds)
   );

   // State register and datapath registers; reset discards any conversion in
   // flight and returns the displays to a plain "0".
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mag_q      <= '0;
         scratch_q  <= '0;
         sign_q     <= 1'b0;
         neg_q      <= 1'b0;
         ones_q     <= '0;
         tens_q     <= '0;
         hundreds_q <= '0;
         hex0_q     <= SEG_ZERO;
         hex1_q     <= LEAD_RESET;
         hex2_q     <= LEAD_RESET;
         hex3_q     <= SEG_BLANK;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mag_q      <= mag_d;
         scratch_q  <= scratch_d;
         sign_q     <= sign_d;
         neg_q      <= neg_d;
         ones_q     <= ones_d;
         tens_q     <= tens_d;
         hundreds_q <= hundreds_d;
         hex0_q     <= hex0_d;
         hex1_q     <= hex1_d;
         hex2_q     <= hex2_d;
         hex3_q     <= hex3_d;
      end
   end

   // Next-state logic. Visible outputs only move in LOAD, so a held Start or a
   // changing Value can never disturb what the displays show mid-conversion.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mag_d      = mag_q;
      scratch_d  = scratch_q;
      sign_d     = sign_q;
      neg_d      = neg_q;
      ones_d     = ones_q;
      tens_d     = tens_q;
      hundreds_d = hundreds_q;
      hex0_d     = hex0_q;
      hex1_d     = hex1_q;
      hex2_d     = hex2_q;
      hex3_d     = hex3_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               sign_d    = signIn;
               mag_d     = magIn;
               scratch_d = '0;
               cnt_d     = '0;
               state_d   = CONVERT;
            end
         end
         CONVERT: begin
            scratch_d = shiftedWord[19:8];
            mag_d     = shiftedWord[7:0];
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            ones_d     = scratch_q[3:0];
            tens_d     = scratch_q[7:4];
            hundreds_d = scratch_q[11:8];
            neg_d      = sign_q;
            hex0_d     = segOnes;
            hex1_d     = segTens;
            hex2_d     = segHundreds;
            hex3_d     = sign_q ? SEG_MINUS : SEG_BLANK;
            state_d    = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o     = (state_q == CONVERT) || (state_q == LOAD);
   assign done_o     = (state_q == DONE);
   assign negative_o = neg_q;
   assign ones_o     = ones_q;
   assign tens_o     = tens_q;
   assign hundreds_o = hundreds_q;
   assign hex0_o     = hex0_q;
   assign hex1_o     = hex1_q;
   assign hex2_o     = hex2_q;
   assign hex3_o     = hex3_q;

endmodule

// File: tb/tb_signed_bcd_display_unit.sv
// -----------------------------------------------------------------------------
// tb_signed_bcd_display_unit
// Two instances share clock and reset: one in signed mode, one in unsigned
// mode, both with leading-zero blanking. Stimulus pushes hand-computed
// expected results into a per-instance queue; a monitor per instance pops and
// compares whenever Done is seen, including the 9-clock latency.
// -----------------------------------------------------------------------------
module tb_signed_bcd_display_unit;

   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [6:0] SM = 7'b0111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;

   typedef struct {
      logic       neg;
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
      logic [6:0] x3;
      logic [6:0] x2;
      logic [6:0] x1;
      logic [6:0] x0;
      int         acceptEdge;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       startS = 1'b0;
   logic       startU = 1'b0;
   logic [7:0] valueS = 8'd0;
   logic [7:0] valueU = 8'd0;

   logic       busyS, doneS, negS;
   logic [3:0] onesS, tensS, hundS;
   logic [6:0] hex0S, hex1S, hex2S, hex3S;
   logic       busyU, doneU, negU;
   logic [3:0] onesU, tensU, hundU;
   logic [6:0] hex0U, hex1U, hex2U, hex3U;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t expS[$];
   exp_t expU[$];

   signed_bcd_display_unit #(.SIGNED_MODE(1'b1), .BLANK_LEADING(1'b1)) dutS (
      .clock_i(clock), .reset_i(reset), .start_i(startS), .value_i(valueS),
      .busy_o(busyS), .done_o(doneS), .negative_o(negS),
      .ones_o(onesS), .tens_o(tensS), .hundreds_o(hundS),
      .hex0_o(hex0S), .hex1_o(hex1S), .hex2_o(hex2S), .hex3_o(hex3S)
   );

   signed_bcd_display_unit #(.SIGNED_MODE(1'b0), .BLANK_LEADING(1'b1)) dutU (
      .clock_i(clock), .reset_i(reset), .start_i(startU), .value_i(valueU),
      .busy_o(busyU), .done_o(doneU), .negative_o(negU),
      .ones_o(onesU), .tens_o(tensU), .hundreds_o(hundU),
      .hex0_o(hex0U), .hex1_o(hex1U), .hex2_o(hex2U), .hex3_o(hex3U)
   );

   // Free-running clock and an edge counter used for latency checks.
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Single comparison point: every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mkExp(input logic neg, input logic [3:0] h,
                                  input logic [3:0] t, input logic [3:0] o,
                                  input logic [6:0] x3, input logic [6:0] x2,
                                  input logic [6:0] x1, input logic [6:0] x0);
      exp_t e;
      e.neg = neg; e.h = h; e.t = t; e.o = o;
      e.x3 = x3; e.x2 = x2; e.x1 = x1; e.x0 = x0;
      e.acceptEdge = 0;
      return e;
   endfunction

   // Called at a falling edge: pulses Start for the next rising edge, records
   // that edge as the accepting edge, then scrambles Value afterwards.
   task automatic applyStimulus(input bit toUnsigned, input logic [7:0] v,
                                input bit expectIt, input exp_t e);
      exp_t item;
      item = e;
      item.acceptEdge = cyc + 1;
      if (toUnsigned) begin
         startU = 1'b1; valueU = v;
         if (expectIt) expU.push_back(item);
      end else begin
         startS = 1'b1; valueS = v;
         if (expectIt) expS.push_back(item);
      end
      @(negedge clock);
      startS = 1'b0; startU = 1'b0;
      valueS = 8'hAA; valueU = 8'hAA;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while ((expS.size() != 0 || expU.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expS.size() + expU.size());
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic checkResetState();
      checkOutput("rst_busy", busyS, 1'b0);
      checkOutput("rst_done", doneS, 1'b0);
      checkOutput("rst_neg", negS, 1'b0);
      checkOutput("rst_digits", {hundS, tensS, onesS}, 12'h000);
      checkOutput("rst_hex0", hex0S, S0);
      checkOutput("rst_hex1", hex1S, SB);
      checkOutput("rst_hex2", hex2S, SB);
      checkOutput("rst_hex3", hex3S, SB);
   endtask

   // Monitor for the signed instance.
   always @(negedge clock) begin
      if (!reset && doneS) begin
         if (expS.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done_s: got done=1, expected no pulse (t=%0t)", $time);
         end else begin
            exp_t e;
            e = expS.pop_front();
            checkOutput("s_latency", cyc, e.acceptEdge + 9);
            checkOutput("s_busy_in_done", busyS, 1'b0);
            checkOutput("s_neg", negS, e.neg);
            checkOutput("s_digits", {hundS, tensS, onesS}, {e.h, e.t, e.o});
            checkOutput("s_hex3", hex3S, e.x3);
            checkOutput("s_hex2", hex2S, e.x2);
            checkOutput("s_hex1", hex1S, e.x1);
            checkOutput("s_hex0", hex0S, e.x0);
         end
      end
   end

   // Monitor for the unsigned instance.
   always @(negedge clock) begin
      if (!reset && doneU) begin
         if (expU.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done_u: got done=1, expected no pulse (t=%0t)", $time);
         end else begin
            exp_t e;
            e = expU.pop_front();
            checkOutput("u_latency", cyc, e.acceptEdge + 9);
            checkOutput("u_neg", negU, e.neg);
            checkOutput("u_digits", {hundU, tensU, onesU}, {e.h, e.t, e.o});
            checkOutput("u_hex3", hex3U, e.x3);
            checkOutput("u_hex2", hex2U, e.x2);
            checkOutput("u_hex1", hex1U, e.x1);
            checkOutput("u_hex0", hex0U, e.x0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int a;

      // Reset state.
      repeat (2) @(negedge clock);
      checkResetState();
      reset = 1'b0;
      @(negedge clock);

      // Signed -13.
      applyStimulus(1'b0, 8'hF3, 1'b1, mkExp(1'b1, 4'd0, 4'd1, 4'd3, SM, SB, S1, S3));
      waitDrain(40);

      // Reset in the middle of a conversion of 99.
      applyStimulus(1'b0, 8'd99, 1'b0, mkExp(1'b0, 4'd0, 4'd9, 4'd9, SB, SB, S9dummy(), S9dummy()));
      repeat (3) @(negedge clock);
      checkOutput("pre_abort_busy", busyS, 1'b1);
      #2 reset = 1'b1;
      #1 checkResetState();
      @(negedge clock);
      reset = 1'b0;
      repeat (12) @(negedge clock);
      checkOutput("post_abort_hex0", hex0S, S0);
      checkOutput("post_abort_busy", busyS, 1'b0);

      // Signed extremes.
      applyStimulus(1'b0, 8'h80, 1'b1, mkExp(1'b1, 4'd1, 4'd2, 4'd8, SM, S1, S2, S8));
      waitDrain(40);
      applyStimulus(1'b0, 8'h7F, 1'b1, mkExp(1'b0, 4'd1, 4'd2, 4'd7, SB, S1, S2, S7));
      waitDrain(40);

      // Unsigned max, zero, and an inner zero that must stay lit.
      applyStimulus(1'b1, 8'hFF, 1'b1, mkExp(1'b0, 4'd2, 4'd5, 4'd5, SB, S2, S5, S5));
      waitDrain(40);
      applyStimulus(1'b1, 8'd0, 1'b1, mkExp(1'b0, 4'd0, 4'd0, 4'd0, SB, SB, SB, S0));
      waitDrain(40);
      applyStimulus(1'b1, 8'd200, 1'b1, mkExp(1'b0, 4'd2, 4'd0, 4'd0, SB, S2, S0, S0));
      waitDrain(40);

      // 42 with Start re-pulsed at E3 and during DONE; Busy traced E0..E11.
      a = cyc + 1;
      applyStimulus(1'b0, 8'd42, 1'b1, mkExp(1'b0, 4'd0, 4'd4, 4'd2, SB, SB, S4, S2));
      for (int k = 0; k <= 11; k++) begin
         checkOutput($sformatf("busy_k%0d", k), busyS, (k <= 8) ? 1'b1 : 1'b0);
         if (k == 2 || k == 9) begin
            startS = 1'b1; valueS = 8'd7;
         end else begin
            startS = 1'b0;
         end
         @(negedge clock);
      end
      checkOutput("ignored_cycle", cyc, a + 12);
      waitDrain(40);

      // Held Start with constant 5: one conversion every 11 cycles, display
      // never leaves "5".
      applyStimulus(1'b0, 8'd5, 1'b1, mkExp(1'b0, 4'd0, 4'd0, 4'd5, SB, SB, SB, S5));
      waitDrain(40);
      startS = 1'b1; valueS = 8'd5;
      a = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e = mkExp(1'b0, 4'd0, 4'd0, 4'd5, SB, SB, SB, S5);
         e.acceptEdge = a + 11 * i;
         expS.push_back(e);
      end
      for (int k = 0; k <= 31; k++) begin
         @(negedge clock);
         checkOutput("held_hex", {hex2S, hex1S, hex0S}, {SB, SB, S5});
         checkOutput("held_digits", {hundS, tensS, onesS}, 12'h005);
         if (k == 31) startS = 1'b0;
      end
      waitDrain(40);

      checkOutput("queue_s_empty", expS.size(), 0);
      checkOutput("queue_u_empty", expU.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Segment pattern for nine, used only to fill the expectation record of
   // the aborted conversion, which is never queued or compared.
   function automatic logic [6:0] S9dummy();
      return 7'b0010000;
   endfunction

endmodule
